// File: rtl/user_io_master.sv
// user_io_master: SPI master (mode 0, MSB first) for the user_io control channel.
// It frames one command byte plus 0-3 payload bytes per request and captures the
// first MISO byte as the core-type code.
//
// Ports:
//   clk, _rst          clock, asynchronous active-low reset
//   req                start request, sampled only while idle
//   cmd, len, data     command byte, payload count (0-3), payload (data[7:0] sent first)
//   busy, done         transaction in progress / one-cycle end-of-transaction pulse
//   core_type(_valid)  first MISO byte of the last completed transaction
//   spi_sck, _spi_ss, spi_mosi, spi_miso  SPI pins (all outputs registered)
module user_io_master #(
  parameter int unsigned CLK_DIV = 4
) (
  input  logic        clk,
  input  logic        _rst,
  input  logic        req,
  input  logic [7:0]  cmd,
  input  logic [1:0]  len,
  input  logic [23:0] data,
  output logic        busy,
  output logic        done,
  output logic [7:0]  core_type,
  output logic        core_type_valid,
  output logic        spi_sck,
  output logic        _spi_ss,
  output logic        spi_mosi,
  input  logic        spi_miso
);

  localparam int unsigned DivW = (CLK_DIV > 1) ? $clog2(CLK_DIV) : 1;
  localparam logic [DivW-1:0] DivLast = DivW'(CLK_DIV - 1);

  typedef enum logic [2:0] {
    StIdle, StSetup, StSckLo, StSckHi, StHold, StGuard
  } state_e;

  state_e          state_q, state_d;
  logic [DivW-1:0] div_q, div_d;
  logic [4:0]      bit_q, bit_d;
  logic [1:0]      len_q, len_d;
  logic [31:0]     tx_q, tx_d;
  logic [7:0]      rx_q, rx_d;
  logic [7:0]      core_type_q, core_type_d;
  logic            core_type_valid_q, core_type_valid_d;
  logic            busy_q, busy_d;
  logic            done_q, done_d;
  logic            sck_q, sck_d;
  logic            ss_n_q, ss_n_d;

  logic div_wrap;
  logic last_bit;

  assign div_wrap = (div_q == DivLast);
  // Index of the final bit is 8*(len+1)-1.
  assign last_bit = (bit_q == {len_q, 3'b111});

  // State and datapath registers.
  always_ff @(posedge clk or negedge _rst) begin
    if (!_rst) begin
      state_q           <= StIdle;
      div_q             <= '0;
      bit_q             <= '0;
      len_q             <= '0;
      tx_q              <= '0;
      rx_q              <= '0;
      core_type_q       <= '0;
      core_type_valid_q <= 1'b0;
      busy_q            <= 1'b0;
      done_q            <= 1'b0;
      sck_q             <= 1'b0;
      ss_n_q            <= 1'b1;
    end else begin
      state_q           <= state_d;
      div_q             <= div_d;
      bit_q             <= bit_d;
      len_q             <= len_d;
      tx_q              <= tx_d;
      rx_q              <= rx_d;
      core_type_q       <= core_type_d;
      core_type_valid_q <= core_type_valid_d;
      busy_q            <= busy_d;
      done_q            <= done_d;
      sck_q             <= sck_d;
      ss_n_q            <= ss_n_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      StIdle:  if (req) state_d = StSetup;
      StSetup: if (div_wrap) state_d = StSckLo;
      StSckLo: if (div_wrap) state_d = StSckHi;
      StSckHi: if (div_wrap) state_d = last_bit ? StHold : StSckLo;
      StHold:  if (div_wrap) state_d = StGuard;
      // Guard spans two divider periods; bit_q[0] marks the second one.
      StGuard: if (div_wrap && bit_q[0]) state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  // Datapath and registered-output next values.
  always_comb begin
    div_d             = div_q;
    bit_d             = bit_q;
    len_d             = len_q;
    tx_d              = tx_q;
    rx_d              = rx_q;
    core_type_d       = core_type_q;
    core_type_valid_d = core_type_valid_q;

    if (state_q != StIdle) div_d = div_wrap ? '0 : div_q + 1'b1;

    case (state_q)
      StIdle: begin
        if (req) begin
          len_d = len;
          bit_d = '0;
          rx_d  = '0;
          // Unused payload bytes are zeroed so MOSI idles low after the frame.
          tx_d  = {cmd,
                   (len >= 2'd1) ? data[7:0]   : 8'h00,
                   (len >= 2'd2) ? data[15:8]  : 8'h00,
                   (len == 2'd3) ? data[23:16] : 8'h00};
        end
      end
      StSckLo: begin
        // This edge raises SCK: capture MISO for the first byte only.
        if (div_wrap && (bit_q < 5'd8)) rx_d = {rx_q[6:0], spi_miso};
      end
      StSckHi: begin
        if (div_wrap) begin
          bit_d = bit_q + 5'd1;
          tx_d  = {tx_q[30:0], 1'b0};
        end
      end
      StHold: if (div_wrap) bit_d = '0;
      StGuard: begin
        if (div_wrap) begin
          bit_d = bit_q[0] ? 5'd0 : 5'd1;
          if (bit_q[0]) begin
            core_type_d       = rx_q;
            core_type_valid_d = 1'b1;
          end
        end
      end
      default: ;
    endcase

    busy_d = (state_d != StIdle);
    sck_d  = (state_d == StSckHi);
    ss_n_d = (state_d == StIdle) || (state_d == StGuard);
    done_d = (state_q == StGuard) && (state_d == StIdle);
  end

  assign busy            = busy_q;
  assign done            = done_q;
  assign core_type       = core_type_q;
  assign core_type_valid = core_type_valid_q;
  assign spi_sck         = sck_q;
  assign _spi_ss         = ss_n_q;
  assign spi_mosi        = tx_q[31];

endmodule

// File: tb/tb_user_io_master.sv
// Bench for user_io_master: closed-form timing model plus an SPI slave model,
// directed frames from the test plan and a randomized frame loop.
module tb_user_io_master;

  localparam int D = 4;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        req = 1'b0;
  logic [7:0]  cmd = 8'h00;
  logic [1:0]  len = 2'd0;
  logic [23:0] data = 24'h0;
  logic        spi_miso = 1'b0;
  logic        busy, done, core_type_valid, spi_sck, spi_ss_n, spi_mosi;
  logic [7:0]  core_type;

  int checks = 0;
  int errors = 0;

  user_io_master #(.CLK_DIV(D)) dut (
    .clk             (clk),
    ._rst            (rst_n),
    .req             (req),
    .cmd             (cmd),
    .len             (len),
    .data            (data),
    .busy            (busy),
    .done            (done),
    .core_type       (core_type),
    .core_type_valid (core_type_valid),
    .spi_sck         (spi_sck),
    ._spi_ss         (spi_ss_n),
    .spi_mosi        (spi_mosi),
    .spi_miso        (spi_miso)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- SPI slave model ----------------
  logic [7:0]  slave_ret = 8'h00;
  logic [31:0] slv_rx = 32'h0;
  int          slv_rises = 0;
  int          rises_total = 0;

  always @(negedge spi_ss_n) begin
    slv_rx    = 32'h0;
    slv_rises = 0;
    spi_miso  = slave_ret[7];
  end

  always @(posedge spi_sck) begin
    slv_rx = {slv_rx[30:0], spi_mosi};
    slv_rises++;
    rises_total++;
  end

  always @(negedge spi_sck) begin
    if (spi_ss_n === 1'b0)
      spi_miso = (slv_rises < 8) ? slave_ret[7 - slv_rises] : 1'($urandom);
  end

  // ---------------- behavioural timing model ----------------
  int          cyc = 0;
  logic        m_active = 1'b0;
  int          m_start = 0;
  int          m_n = 8;
  logic [31:0] m_wire = 32'h0;
  logic [7:0]  m_ret = 8'h00;
  logic [7:0]  m_ct = 8'h00;
  logic        m_ctv = 1'b0;
  logic        e_busy = 1'b0, e_done = 1'b0, e_sck = 1'b0, e_ss = 1'b1;
  logic        e_mosi = 1'b0, e_mosi_chk = 1'b0;

  function automatic int frame_len(input int n);
    return 2 * D * (n + 2);
  endfunction

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_active = 1'b0; m_ct = 8'h00; m_ctv = 1'b0;
      e_busy = 1'b0; e_done = 1'b0; e_sck = 1'b0; e_ss = 1'b1;
      e_mosi = 1'b0; e_mosi_chk = 1'b0;
    end else begin
      int t;
      if (!(m_active && (cyc - m_start) < frame_len(m_n)) && req) begin
        m_active = 1'b1;
        m_start  = cyc + 1;
        m_n      = 8 * (int'(len) + 1);
        m_wire   = {cmd, data[7:0], data[15:8], data[23:16]};
        m_ret    = slave_ret;
      end
      cyc++;
      e_busy = 1'b0; e_done = 1'b0; e_sck = 1'b0; e_ss = 1'b1; e_mosi_chk = 1'b0;
      if (m_active) begin
        t = cyc - m_start;
        e_busy = (t < frame_len(m_n));
        e_done = (t == frame_len(m_n));
        e_ss   = (t >= 2 * D * (m_n + 1));
        if (t < D) begin
          e_mosi_chk = 1'b1;
          e_mosi     = m_wire[31];
        end else if (t < D + 2 * D * m_n) begin
          e_mosi_chk = 1'b1;
          e_mosi     = m_wire[31 - (t - D) / (2 * D)];
          e_sck      = (((t - D) % (2 * D)) >= D);
        end
        if (e_done) begin
          m_ct  = m_ret;
          m_ctv = 1'b1;
        end
      end
    end
  end

  // Single compare process, every cycle.
  always @(negedge clk) begin
    check("busy", busy, e_busy);
    check("done", done, e_done);
    check("sck", spi_sck, e_sck);
    check("ss_n", spi_ss_n, e_ss);
    check("core_type", core_type, m_ct);
    check("core_type_valid", core_type_valid, m_ctv);
    if (e_mosi_chk) check("mosi", spi_mosi, e_mosi);
  end

  // ---------------- stimulus ----------------
  task automatic run_frame(input logic [7:0] c, input logic [1:0] l, input logic [23:0] d,
                           input logic [7:0] ret, input int pulse_at,
                           output int bcnt, output int dcnt);
    @(negedge clk);
    cmd = c; len = l; data = d; slave_ret = ret; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    bcnt = 0;
    for (int i = 0; i < 2000 && !done; i++) begin
      req = (i == pulse_at);
      if (busy) bcnt++;
      @(negedge clk);
    end
    req = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL frame_timeout: got done=0 expected done=1");
    end
    dcnt = int'(done);
    @(negedge clk);
    dcnt += int'(done);
  endtask

  function automatic logic [31:0] wire_bits(input logic [7:0] c, input logic [1:0] l,
                                            input logic [23:0] d);
    logic [31:0] w;
    w = {c, d[7:0], d[15:8], d[23:16]};
    return w >> (8 * (3 - int'(l)));
  endfunction

  initial begin
    int bcnt, dcnt, gap, dseen, r0;
    logic [7:0]  c, ret;
    logic [1:0]  l;
    logic [23:0] d;

    // Reset held with req high: nothing moves.
    req = 1'b1;
    repeat (12) @(negedge clk);
    check("reset_no_sck", rises_total, 0);
    check("reset_ss", spi_ss_n, 1'b1);
    rst_n = 1'b1;
    req   = 1'b0;
    repeat (5) @(negedge clk);
    check("idle_after_reset", busy, 1'b0);

    // Joystick frame.
    run_frame(8'h02, 2'd1, 24'h000015, 8'hA1, -1, bcnt, dcnt);
    check("joy_busy_cycles", bcnt, 144);
    check("joy_rises", slv_rises, 16);
    check("joy_bytes", slv_rx, 32'h0000_0215);
    check("joy_done_pulses", dcnt, 1);
    check("joy_core_type", core_type, 8'hA1);
    check("joy_core_valid", core_type_valid, 1'b1);

    // Second frame updates core_type.
    run_frame(8'h03, 2'd0, 24'h0, 8'h5A, -1, bcnt, dcnt);
    check("ct2_core_type", core_type, 8'h5A);
    check("ct2_rises", slv_rises, 8);

    // Mouse frame, full payload.
    run_frame(8'h04, 2'd3, 24'h01FE05, 8'h77, -1, bcnt, dcnt);
    check("mouse_bytes", slv_rx, 32'h0405_FE01);
    check("mouse_rises", slv_rises, 32);
    check("mouse_busy_cycles", bcnt, 272);

    // req pulsed mid-frame is dropped.
    run_frame(8'h05, 2'd0, 24'h0, 8'h11, 10, bcnt, dcnt);
    repeat (3 * D) @(negedge clk);
    check("req_ignored", busy, 1'b0);

    // Held req: back-to-back frames, accept in the done cycle.
    @(negedge clk);
    cmd = 8'h05; len = 2'd0; data = 24'h0; slave_ret = 8'hC3; req = 1'b1;
    for (int i = 0; i < 400 && spi_ss_n; i++) @(negedge clk);
    for (int i = 0; i < 400 && !spi_ss_n; i++) @(negedge clk);
    gap = 0; dseen = 0;
    for (int i = 0; i < 400 && spi_ss_n; i++) begin
      gap++;
      if (done) dseen++;
      @(negedge clk);
    end
    check("b2b_ss_gap", gap, 2 * D + 1);
    check("b2b_done_in_gap", dseen, 1);
    check("b2b_second_busy", busy, 1'b1);
    for (int i = 0; i < 400 && !done; i++) @(negedge clk);
    req = 1'b0;
    @(negedge clk);
    check("b2b_stop", busy, 1'b0);
    check("b2b_core_type", core_type, 8'hC3);

    // Asynchronous reset part-way through the command byte.
    @(negedge clk);
    cmd = 8'h05; len = 2'd2; data = 24'h00BEEF; slave_ret = 8'h3C; req = 1'b1;
    @(negedge clk);
    req = 1'b0;
    for (int i = 0; i < 400 && slv_rises < 6; i++) @(negedge clk);
    r0 = rises_total;
    #2;
    rst_n = 1'b0;
    #1;
    check("arst_sck", spi_sck, 1'b0);
    check("arst_ss", spi_ss_n, 1'b1);
    check("arst_core_type", core_type, 8'h00);
    check("arst_core_valid", core_type_valid, 1'b0);
    check("arst_busy", busy, 1'b0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    check("arst_no_sck", rises_total, r0);
    run_frame(8'h05, 2'd2, 24'h00BEEF, 8'h3C, -1, bcnt, dcnt);
    check("post_rst_bytes", slv_rx, 32'h0005_EFBE);
    check("post_rst_rises", slv_rises, 24);
    check("post_rst_core_type", core_type, 8'h3C);

    // Randomized frames.
    for (int k = 0; k < 14; k++) begin
      c   = 8'($urandom);
      l   = 2'($urandom);
      d   = 24'($urandom);
      ret = 8'($urandom);
      run_frame(c, l, d, ret, int'($urandom_range(0, 60)), bcnt, dcnt);
      check("rnd_bytes", slv_rx, wire_bits(c, l, d));
      check("rnd_rises", slv_rises, 8 * (int'(l) + 1));
      check("rnd_busy_cycles", bcnt, frame_len(8 * (int'(l) + 1)));
      check("rnd_core_type", core_type, ret);
      repeat ($urandom_range(0, 5)) @(negedge clk);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

endmodule
